// File: rtl/cache_pkg.sv
// Shared definitions for the D-cache refill path: FSM state codes, block
// geometry and the word-index helper used to walk a block in wrap order.
package cache_pkg;

    localparam int BLOCK_WORDS = 8;
    localparam int OFFSET_W    = 3;
    localparam int TAG_BASE_W  = 12;
    localparam int ISSUE_W     = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Word indices wrap modulo the block size.
    localparam logic [OFFSET_W-1:0] WORD_IDX_MASK = 3'b111;
    localparam logic [OFFSET_W-1:0] LAST_WORD     = 3'd7;
    localparam logic [ISSUE_W-1:0]  LAST_ISSUE    = 4'd7;

    // Index of the cnt-th word of a block walked from word start.
    function automatic logic [OFFSET_W-1:0] wordIndex(
        input logic [OFFSET_W-1:0] start,
        input logic [OFFSET_W-1:0] cnt
    );
        wordIndex = (start + cnt) & WORD_IDX_MASK;
    endfunction

endpackage

// File: rtl/fill_counter.sv
// Small up-counter with synchronous active-low reset, synchronous clear,
// count enable and a flag that is high while the count equals TERM.
module fill_counter #(
    parameter int             W    = 3,
    parameter logic [W-1:0]   TERM = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         term
);

    // Count enabled events; clear restarts the count for a new block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign term = (count == TERM);

endmodule

// File: rtl/dcache_fill_fsm.sv
// D-cache miss refill controller. Accepts a miss in IDLE, issues eight
// pipelined word reads for the 16-byte victim block, steers every returning
// word into the data array and finishes with a single tag write.
//
// Optional feature macro: FILL_CRITICAL_WORD_FIRST_EN
//   defined   -> requests and writes start at the missing word and wrap
//   undefined -> requests and writes always run word 0..7
//
// Memory handshake: mem_req/memory_address form a fire-and-forget request,
// one word per cycle with no ready signal; memory_data_valid marks a word
// returned in request order, again with no backpressure. Only valids seen in
// FILL are consumed; anything arriving in IDLE or DONE is dropped.
module dcache_fill_fsm
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    output logic        fsm_busy,
    output logic        mem_req,
    output logic [15:0] memory_address,
    input  logic        memory_data_valid,
    input  logic [15:0] memory_data,
    output logic        write_data_array,
    output logic [15:0] fill_data,
    output logic [2:0]  word_offset,
    output logic        write_tag_array,
    output logic        fill_done,
    output logic [1:0]  fsm_state
);

    logic [1:0]            state;
    logic [1:0]            nextState;
    logic [TAG_BASE_W-1:0] blockBase;
    logic [ISSUE_W-1:0]    issueCnt;
    logic                  issueLast;
    logic [OFFSET_W-1:0]   recvCnt;
    logic                  recvLast;
    logic                  accept;
    logic                  issueEn;
    logic [OFFSET_W-1:0]   firstIdx;
    logic [OFFSET_W-1:0]   nextIssueIdx;
    logic [OFFSET_W-1:0]   recvIdx;
    logic                  unusedBits;

    assign accept  = (state == IDLE) && miss_detected;
    assign issueEn = (state == FILL) && mem_req;

`ifdef FILL_CRITICAL_WORD_FIRST_EN
    logic [OFFSET_W-1:0] startWord;

    // Remember which word missed so both request and write order start there.
    always_ff @(posedge clk) begin
        if (!rst) begin
            startWord <= '0;
        end else if (accept) begin
            startWord <= miss_address[3:1];
        end
    end

    assign firstIdx     = miss_address[3:1];
    assign nextIssueIdx = wordIndex(startWord, issueCnt[OFFSET_W-1:0] + 3'd1);
    assign recvIdx      = wordIndex(startWord, recvCnt);
`else
    assign firstIdx     = '0;
    assign nextIssueIdx = issueCnt[OFFSET_W-1:0] + 3'd1;
    assign recvIdx      = recvCnt;
`endif

    // Byte-select bit and the issue counter's top bit are not needed here.
    assign unusedBits = ^{miss_address[3:0], issueCnt[ISSUE_W-1]};

    fill_counter #(
        .W    (ISSUE_W),
        .TERM (LAST_ISSUE)
    ) issueCounter (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (issueEn),
        .count (issueCnt),
        .term  (issueLast)
    );

    fill_counter #(
        .W    (OFFSET_W),
        .TERM (LAST_WORD)
    ) recvCounter (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (write_data_array),
        .count (recvCnt),
        .term  (recvLast)
    );

    // Next-state selection: accept a miss, finish on the last word, one DONE cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (miss_detected) nextState = FILL;
            FILL:    if (write_tag_array) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State, block base and the registered request/busy outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            blockBase      <= '0;
            mem_req        <= 1'b0;
            memory_address <= '0;
            fsm_busy       <= 1'b0;
        end else begin
            state <= nextState;
            if (accept) begin
                blockBase      <= miss_address[15:4];
                mem_req        <= 1'b1;
                memory_address <= {miss_address[15:4], firstIdx, 1'b0};
                fsm_busy       <= 1'b1;
            end else if (state != FILL) begin
                mem_req        <= 1'b0;
                memory_address <= '0;
                if (state == DONE) begin
                    fsm_busy <= 1'b0;
                end
            end else if (issueEn) begin
                mem_req        <= !issueLast;
                memory_address <= issueLast ? '0 : {blockBase, nextIssueIdx, 1'b0};
            end
        end
    end

    // Write path is combinational so each word lands in the cycle it returns.
    assign write_data_array = rst && (state == FILL) && memory_data_valid;
    assign word_offset      = write_data_array ? recvIdx : '0;
    assign fill_data        = write_data_array ? memory_data : '0;
    assign write_tag_array  = write_data_array && recvLast;
    assign fill_done        = write_tag_array;
    assign fsm_state        = state;

endmodule

// File: tb/tb_dcache_fill_fsm.sv
// Bench for dcache_fill_fsm: a pipelined memory model with optional response
// gaps, a cycle-level reference model built from whole-block request/write
// lists, a vector table of fills with hand-derived timing, and hand-written
// sequences for reset mid-fill and back-to-back misses.
module tb_dcache_fill_fsm;

    localparam int MEM_LAT = 4;

    typedef struct {
        logic [15:0] addr;
        int          gap;
        bit          hold;
        logic [15:0] firstReq;
        logic [15:0] lastReq;
        logic [2:0]  firstOff;
        logic [2:0]  lastOff;
        int          tagAt;
        int          lowAt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        mem_req;
    logic [15:0] memory_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        write_data_array;
    logic [15:0] fill_data;
    logic [2:0]  word_offset;
    logic        write_tag_array;
    logic        fill_done;
    logic [1:0]  fsm_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog cycle=%0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    dcache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .mem_req           (mem_req),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .write_data_array  (write_data_array),
        .fill_data         (fill_data),
        .word_offset       (word_offset),
        .write_tag_array   (write_tag_array),
        .fill_done         (fill_done),
        .fsm_state         (fsm_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [15:0] memWord(input logic [15:0] a);
        return a ^ 16'h5A3C ^ {a[7:0], a[15:8]};
    endfunction

    // ---------------- memory model (driver) ----------------
    logic [15:0] rspAddr[$];
    int          rspDue[$];
    int          memGap = 0;
    int          lastDue = 0;
    bit          spurious = 0;

    initial begin
        memory_data_valid = 1'b0;
        memory_data = '0;
        forever begin
            @(posedge clk);
            #1;
            memory_data_valid = 1'b0;
            memory_data = 16'($urandom);
            if (rspAddr.size() != 0 && rspDue[0] <= cyc) begin
                memory_data_valid = 1'b1;
                memory_data = memWord(rspAddr.pop_front());
                void'(rspDue.pop_front());
            end else if (spurious && $urandom_range(0, 1) == 1) begin
                memory_data_valid = 1'b1;
            end
            @(negedge clk);
            if (mem_req === 1'b1) begin
                int due;
                due = cyc + MEM_LAT;
                if (due < lastDue + 1 + memGap) due = lastDue + 1 + memGap;
                rspAddr.push_back(memory_address);
                rspDue.push_back(due);
                lastDue = due;
            end
        end
    end

    // ---------------- reference model / scoreboard ----------------
    bit          monOn = 0;
    bit          mBusy = 0;
    bit          mFill = 0;
    bit          mDone = 0;
    logic [15:0] reqExp[$];
    logic [15:0] exp_q[$];

    initial forever begin
        @(negedge clk);
        if (monOn) begin
            logic        eStrobe;
            logic        eTag;
            logic [15:0] eAddr;
            eStrobe = rst && mFill && memory_data_valid;
            eTag = eStrobe && (exp_q.size() == 1);
            check("busy", fsm_busy, mBusy);
            check("mem_req", mem_req, reqExp.size() != 0);
            if (reqExp.size() != 0) check("mem_addr", memory_address, reqExp.pop_front());
            check("strobe", write_data_array, eStrobe);
            if (eStrobe && exp_q.size() != 0) begin
                eAddr = exp_q.pop_front();
                check("word_offset", word_offset, eAddr[3:1]);
                check("fill_data", fill_data, memWord(eAddr));
            end else begin
                check("word_offset_quiet", word_offset, 3'd0);
                check("fill_data_quiet", fill_data, 16'd0);
            end
            check("tag", write_tag_array, eTag);
            check("fill_done", fill_done, eTag);
            if (!rst) begin
                mBusy = 0; mFill = 0; mDone = 0;
                reqExp.delete();
                exp_q.delete();
            end else if (eTag) begin
                mFill = 0; mDone = 1;
            end else if (mDone) begin
                mDone = 0; mBusy = 0;
            end else if (!mBusy && miss_detected === 1'b1) begin
                logic [2:0] st;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
                st = miss_address[3:1];
`else
                st = 3'd0;
`endif
                for (int i = 0; i < 8; i++) begin
                    logic [15:0] a;
                    a = {miss_address[15:4], 4'b0000} | 16'(((int'(st) + i) % 8) * 2);
                    reqExp.push_back(a);
                    exp_q.push_back(a);
                end
                mBusy = 1; mFill = 1;
            end
        end
    end

    // ---------------- event statistics ----------------
    int          stStrobes, stTags, stReqs, stTagCyc;
    logic [15:0] stFirstReq, stLastReq;
    logic [2:0]  stFirstOff, stLastOff;
    int          busyRise[$];
    logic        prevBusy = 1'b0;

    initial forever begin
        @(negedge clk);
        if (write_data_array === 1'b1) begin
            if (stStrobes == 0) stFirstOff = word_offset;
            stLastOff = word_offset;
            stStrobes++;
        end
        if (write_tag_array === 1'b1) begin
            stTags++;
            stTagCyc = cyc;
        end
        if (mem_req === 1'b1) begin
            if (stReqs == 0) stFirstReq = memory_address;
            stLastReq = memory_address;
            stReqs++;
        end
        if (fsm_busy === 1'b1 && prevBusy !== 1'b1) busyRise.push_back(cyc);
        prevBusy = fsm_busy;
    end

    task automatic clearStats();
        stStrobes = 0; stTags = 0; stReqs = 0; stTagCyc = 0;
        stFirstReq = '0; stLastReq = '0; stFirstOff = '0; stLastOff = '0;
        busyRise.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic checkAllZero(input string pfx);
        check({pfx, "_busy"}, fsm_busy, 1'b0);
        check({pfx, "_mem_req"}, mem_req, 1'b0);
        check({pfx, "_mem_addr"}, memory_address, 16'd0);
        check({pfx, "_strobe"}, write_data_array, 1'b0);
        check({pfx, "_offset"}, word_offset, 3'd0);
        check({pfx, "_fill_data"}, fill_data, 16'd0);
        check({pfx, "_tag"}, write_tag_array, 1'b0);
        check({pfx, "_done"}, fill_done, 1'b0);
    endtask

    task automatic runFill(input logic [15:0] addr, input int gap, input bit hold,
                           output int accAt, output int lowAt);
        for (int i = 0; i < 100 && fsm_busy !== 1'b0; i++) begin
            @(posedge clk); #1;
        end
        clearStats();
        memGap = gap;
        miss_address = addr;
        miss_detected = 1'b1;
        accAt = cyc;
        @(posedge clk); #1;
        if (!hold) miss_detected = 1'b0;
        for (int i = 0; i < 200 && fsm_busy !== 1'b0; i++) begin
            if (stTags != 0) miss_detected = 1'b0;
            @(posedge clk); #1;
        end
        miss_detected = 1'b0;
        check("busy_fall", fsm_busy, 1'b0);
        lowAt = cyc - accAt;
    endtask

    task automatic applyVec(input vec_t v);
        int accAt, lowAt;
        runFill(v.addr, v.gap, v.hold, accAt, lowAt);
        check("v_tag_cycle", stTagCyc - accAt, v.tagAt);
        check("v_busy_low_cycle", lowAt, v.lowAt);
        check("v_strobes", stStrobes, 8);
        check("v_tags", stTags, 1);
        check("v_reqs", stReqs, 8);
        check("v_first_req", stFirstReq, v.firstReq);
        check("v_last_req", stLastReq, v.lastReq);
        check("v_first_off", stFirstOff, v.firstOff);
        check("v_last_off", stLastOff, v.lastOff);
    endtask

    task automatic idleSpurious(input int n);
        clearStats();
        @(negedge clk);
        spurious = 1;
        repeat (n) @(negedge clk);
        spurious = 0;
        @(posedge clk); #1;
        check("idle_strobes", stStrobes, 0);
        check("idle_tags", stTags, 0);
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[4];

    initial begin
        int accAt, lowAt;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
        vecs[0] = '{16'h1236, 0, 1'b0, 16'h1236, 16'h1234, 3'd3, 3'd2, 12, 14};
        vecs[1] = '{16'h40AC, 0, 1'b1, 16'h40AC, 16'h40AA, 3'd6, 3'd5, 12, 14};
        vecs[2] = '{16'hFFFE, 3, 1'b0, 16'hFFFE, 16'hFFFC, 3'd7, 3'd6, 33, 35};
        vecs[3] = '{16'h0001, 1, 1'b1, 16'h0000, 16'h000E, 3'd0, 3'd7, 19, 21};
`else
        vecs[0] = '{16'h1236, 0, 1'b0, 16'h1230, 16'h123E, 3'd0, 3'd7, 12, 14};
        vecs[1] = '{16'h40AC, 0, 1'b1, 16'h40A0, 16'h40AE, 3'd0, 3'd7, 12, 14};
        vecs[2] = '{16'hFFFE, 3, 1'b0, 16'hFFF0, 16'hFFFE, 3'd0, 3'd7, 33, 35};
        vecs[3] = '{16'h0001, 1, 1'b1, 16'h0000, 16'h000E, 3'd0, 3'd7, 19, 21};
`endif
        clearStats();
        rst = 1'b0;
        miss_detected = 1'b0;
        miss_address = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        monOn = 1;

        // Vector table: basic, critical-word, stalled and held-miss fills.
        for (int k = 0; k < 4; k++) begin
            idleSpurious(4);
            applyVec(vecs[k]);
        end

        // Reset after the 4th valid, then a clean refill.
        clearStats();
        memGap = 0;
        miss_address = 16'h2468;
        miss_detected = 1'b1;
        @(posedge clk); #1;
        miss_detected = 1'b0;
        for (int i = 0; i < 100 && stStrobes < 4; i++) begin
            @(posedge clk); #1;
        end
        check("rst_pre_strobes", stStrobes, 4);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("rst_mid");
        for (int i = 0; i < 100 && rspAddr.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("rst_drained", rspAddr.size(), 0);
        check("rst_late_strobes", stStrobes, 4);
        check("rst_late_tags", stTags, 0);
        applyVec(vecs[0]);

        // Back-to-back misses with miss_detected held high.
        clearStats();
        memGap = 0;
        miss_address = 16'h7770;
        miss_detected = 1'b1;
        accAt = cyc;
        for (int i = 0; i < 100 && stTags < 2; i++) begin
            @(posedge clk); #1;
        end
        miss_detected = 1'b0;
        for (int i = 0; i < 100 && fsm_busy !== 1'b0; i++) begin
            @(posedge clk); #1;
        end
        check("b2b_tags", stTags, 2);
        check("b2b_strobes", stStrobes, 16);
        check("b2b_rises", busyRise.size(), 2);
        if (busyRise.size() == 2) begin
            check("b2b_first_rise", busyRise[0] - accAt, 1);
            check("b2b_second_accept", busyRise[1] - busyRise[0], 14);
        end

        // Randomized fills against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            a = 16'($urandom);
            idleSpurious($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            runFill(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)), accAt, lowAt);
            check("rand_strobes", stStrobes, 8);
            check("rand_tags", stTags, 1);
        end

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
